// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - standard DES S-box contents, lane widths and folded-entry helper
package des_pkg;

    localparam int IN_BITS  = 6;
    localparam int OUT_BITS = 4;

    // Each 64-bit word is one textbook row (columns 0..15, column 0 in the top nibble), four rows per box.
    localparam logic [0:7][0:3][63:0] SBOX_ROWS = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    function automatic int in_width(input int num_box);
        return IN_BITS * num_box;
    endfunction

    function automatic int out_width(input int num_box);
        return OUT_BITS * num_box;
    endfunction

    // Row comes from the outer input bits, column from the inner four.
    function automatic logic [3:0] sbox_entry(input logic [2:0] box, input logic [5:0] addr);
        logic [3:0] col;
        col = addr[4:1];
        return SBOX_ROWS[box][{addr[5], addr[0]}][{~col, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/des_sbox_bank_if.sv
// rtl/des_sbox_bank_if.sv - stream and table-write signals of the S-box bank
interface des_sbox_bank_if #(parameter int NUM_BOX = 8);
    import des_pkg::*;

    logic                           in_valid;
    logic                           in_ready;
    logic [in_width(NUM_BOX)-1:0]   in;
    logic                           out_valid;
    logic                           out_ready;
    logic [out_width(NUM_BOX)-1:0]  out;
    logic                           cfg_we;
    logic [3:0]                     cfg_box;
    logic [5:0]                     cfg_addr;
    logic [3:0]                     cfg_data;

    modport master (
        output in_valid, in, out_ready, cfg_we, cfg_box, cfg_addr, cfg_data,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, in, out_ready, cfg_we, cfg_box, cfg_addr, cfg_data,
        output in_ready, out_valid, out
    );

endinterface

// File: rtl/des_sbox_lut.sv
// rtl/des_sbox_lut.sv - one loadable 64x4 lookup table that resets to a standard DES S-box
module des_sbox_lut
    import des_pkg::*;
#(
    parameter int BOX = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [3:0] wdata,
    input  logic [5:0] raddr,
    output logic [3:0] rdata
);

    logic [3:0] tbl [64];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                tbl[i] <= sbox_entry(3'(BOX % 8), 6'(i));
            end
        end else if (we) begin
            tbl[waddr] <= wdata;
        end
    end

    // Combinational read sees the pre-write contents during a write cycle.
    assign rdata = tbl[raddr];

endmodule

// File: rtl/des_sbox_bank.sv
// rtl/des_sbox_bank.sv - two-stage pipelined bank of loadable DES S-box lanes
module des_sbox_bank
    import des_pkg::*;
#(
    parameter int NUM_BOX  = 8,
    parameter int LOADABLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    des_sbox_bank_if.slave        bus
);

    localparam int IW = in_width(NUM_BOX);
    localparam int OW = out_width(NUM_BOX);

    logic          ready_en;
    logic          s1_valid;
    logic [IW-1:0] s1_data;
    logic          s2_valid;
    logic [OW-1:0] s2_data;
    logic [OW-1:0] lookup;
    logic [NUM_BOX-1:0] cfg_hit;
    logic          accept;
    logic          s2_load;

    assign s2_load     = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = ready_en && (!s1_valid || !s2_valid || bus.out_ready);
    assign accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out       = s2_data;

    for (genvar k = 0; k < NUM_BOX; k++) begin : g_lane
        // Lane 0 occupies the most significant slice of both words.
        assign cfg_hit[k] = (LOADABLE != 0) && bus.cfg_we && (bus.cfg_box == 4'(k));

        des_sbox_lut #(.BOX(k % 8)) u_lut (
            .clk   (clk),
            .rst   (rst),
            .we    (cfg_hit[k]),
            .waddr (bus.cfg_addr),
            .wdata (bus.cfg_data),
            .raddr (s1_data[(NUM_BOX-1-k)*IN_BITS +: IN_BITS]),
            .rdata (lookup[(NUM_BOX-1-k)*OUT_BITS +: OUT_BITS])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= bus.in;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            // S2 holds its word until it is taken, so a later table write never alters it.
            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_data  <= lookup;
            end else if (bus.out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_des_sbox_bank.sv
// tb/tb_des_sbox_bank.sv - randomized self-checking bench for des_sbox_bank
module tb_des_sbox_bank;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    des_sbox_bank_if #(.NUM_BOX(8)) bus ();

    des_sbox_bank #(.NUM_BOX(8), .LOADABLE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Textbook DES rows, four per box, column 0 in the top nibble.
    logic [63:0] ref_rows [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    int ref_tbl [8][64];

    function automatic void model_reset();
        int row, col;
        for (int b = 0; b < 8; b++) begin
            for (int x = 0; x < 64; x++) begin
                row = ((x >> 4) & 2) | (x & 1);
                col = (x >> 1) & 15;
                ref_tbl[b][x] = int'((ref_rows[b*4+row] >> ((15 - col) * 4)) & 64'hF);
            end
        end
    endfunction

    function automatic logic [31:0] ref_word(input logic [47:0] w);
        logic [31:0] r;
        int x;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            x = int'(w[(7-k)*6 +: 6]);
            r[(7-k)*4 +: 4] = 4'(ref_tbl[k][x]);
        end
        return r;
    endfunction

    function automatic logic [47:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_box   = '0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
    endtask

    // Entered at posedge+1; samples at posedge+3; returns at the next posedge+1.
    task automatic step(output logic irdy, output logic ov, output logic [31:0] o);
        #2;
        irdy = bus.in_ready;
        ov   = bus.out_valid;
        o    = bus.out;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup_once(input logic [47:0] w, output logic [31:0] o, output int lat);
        logic irdy, ov;
        logic [31:0] oo;
        bit acc;
        lat = -1;
        o   = '0;
        acc = 0;
        bus.in = w;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && !acc; c++) begin
            step(irdy, ov, oo);
            acc = irdy;
        end
        bus.in_valid = 1'b0;
        if (acc) begin
            for (int c = 1; c <= 10 && lat < 0; c++) begin
                step(irdy, ov, oo);
                if (ov) begin
                    o   = oo;
                    lat = c;
                end
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        #3;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 0", bus.out); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #2;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_before_edge got %b want 0", bus.in_ready); end
        @(posedge clk);
        #3;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_after_edge got %b want 1", bus.in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_lookup();
        logic [31:0] o;
        logic irdy, ov;
        int lat;
        lookup_once(48'h0, o, lat);
        checks++; if (o !== 32'hEFA72C4D) begin errors++; $display("FAIL basic_out got %h want efa72c4d", o); end
        checks++; if (o !== ref_word(48'h0)) begin errors++; $display("FAIL basic_model got %h want %h", o, ref_word(48'h0)); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency got %0d want 2", lat); end
        step(irdy, ov, o);
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL basic_no_dup got %b want 0", ov); end
    endtask

    task automatic test_lane4();
        logic [47:0] w;
        logic [31:0] o;
        int lat;
        w = '0;
        w[23:18] = 6'd1;
        lookup_once(w, o, lat);
        checks++; if (o !== 32'hEFA7EC4D) begin errors++; $display("FAIL lane4_one got %h want efa7ec4d", o); end
        w[23:18] = 6'd63;
        lookup_once(w, o, lat);
        checks++; if (o !== 32'hEFA73C4D) begin errors++; $display("FAIL lane4_63 got %h want efa73c4d", o); end
    endtask

    task automatic run_stream(input int n, input bit bp_pattern);
        logic [47:0] words[$];
        logic [31:0] exp_q[$];
        logic [31:0] o, prev_out, e;
        logic irdy, ov;
        logic [47:0] w;
        int sent, got, held, cyc;
        bit prev_stall, saw_full;
        sent = 0; got = 0; held = 0; cyc = 0;
        prev_stall = 0; saw_full = 0; prev_out = '0;
        for (int k = 0; k < n; k++) begin
            w = rand_word();
            w[47:42] = 6'(k);
            words.push_back(w);
        end
        while (got < n && cyc < 20 * n + 50) begin
            bus.in_valid  = (sent < n) && (bp_pattern || ($urandom_range(0, 3) != 0));
            bus.in        = (sent < n) ? words[sent] : '0;
            bus.out_ready = bp_pattern ? !(cyc >= 3 && cyc <= 5) : ($urandom_range(0, 2) != 0);
            step(irdy, ov, o);
            checks++;
            if (irdy !== ((held < 2) || bus.out_ready)) begin
                errors++; $display("FAIL stream_in_ready cyc %0d got %b want %b", cyc, irdy, (held < 2) || bus.out_ready);
            end
            if (prev_stall) begin
                checks++;
                if (ov !== 1'b1 || o !== prev_out) begin
                    errors++; $display("FAIL stream_hold cyc %0d got %b/%h want 1/%h", cyc, ov, o, prev_out);
                end
            end
            if (ov && bus.out_ready) begin
                checks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                if (o !== e) begin errors++; $display("FAIL stream_data word %0d got %h want %h", got, o, e); end
                got++;
                held--;
            end
            if (bus.in_valid && irdy) begin
                exp_q.push_back(ref_word(words[sent]));
                sent++;
                held++;
            end
            checks++;
            if (held > 2 || held < 0) begin errors++; $display("FAIL stream_occupancy got %0d want 0..2", held); end
            if (!irdy) saw_full = 1;
            prev_stall = ov && !bus.out_ready;
            prev_out   = o;
            cyc++;
        end
        idle_inputs();
        checks++; if (got !== n) begin errors++; $display("FAIL stream_count got %0d want %0d", got, n); end
        if (bp_pattern) begin
            checks++; if (!saw_full) begin errors++; $display("FAIL stream_backpressure got no stall want stall"); end
        end
    endtask

    task automatic test_backpressure();
        run_stream(6, 1'b1);
    endtask

    task automatic test_table_write();
        logic [47:0] w;
        logic [31:0] o;
        logic irdy, ov;
        int lat;
        bus.cfg_we = 1'b1; bus.cfg_box = 4'd4; bus.cfg_addr = 6'd0; bus.cfg_data = 4'd9;
        step(irdy, ov, o);
        bus.cfg_we = 1'b0;
        ref_tbl[4][0] = 9;
        lookup_once(48'h0, o, lat);
        checks++; if (o !== 32'hEFA79C4D) begin errors++; $display("FAIL write_visible got %h want efa79c4d", o); end
        w = '0;
        w[23:18] = 6'd1;
        lookup_once(w, o, lat);
        checks++; if (o !== 32'hEFA7EC4D) begin errors++; $display("FAIL write_neighbour got %h want efa7ec4d", o); end
    endtask

    task automatic test_reset_restore();
        logic [31:0] o;
        logic irdy, ov;
        int lat;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.in = rand_word();
            step(irdy, ov, o);
        end
        #2;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midstream_busy got %b want 1", bus.out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL async_in_ready got %b want 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            step(irdy, ov, o);
            checks++; if (ov !== 1'b0) begin errors++; $display("FAIL stale_word cyc %0d got %h want none", c, o); end
        end
        lookup_once(48'h0, o, lat);
        checks++; if (o !== 32'hEFA72C4D) begin errors++; $display("FAIL restore_out got %h want efa72c4d", o); end
    endtask

    task automatic test_same_cycle_write();
        logic [31:0] o;
        logic irdy, ov;
        int lat;
        bus.in = '0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step(irdy, ov, o);
        checks++; if (irdy !== 1'b1) begin errors++; $display("FAIL same_cycle_accept got %b want 1", irdy); end
        bus.in_valid = 1'b0;
        bus.cfg_we = 1'b1; bus.cfg_box = 4'd4; bus.cfg_addr = 6'd0; bus.cfg_data = 4'd9;
        step(irdy, ov, o);
        bus.cfg_we = 1'b0;
        step(irdy, ov, o);
        checks++; if (ov !== 1'b1 || o !== 32'hEFA72C4D) begin errors++; $display("FAIL same_cycle_old got %b/%h want 1/efa72c4d", ov, o); end
        ref_tbl[4][0] = 9;
        lookup_once(48'h0, o, lat);
        checks++; if (o !== 32'hEFA79C4D) begin errors++; $display("FAIL same_cycle_new got %h want efa79c4d", o); end
    endtask

    task automatic test_out_of_range();
        logic [47:0] w;
        logic [31:0] o;
        logic irdy, ov;
        int lat;
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_box  = (i == 0) ? 4'd12 : 4'(8 + $urandom_range(0, 7));
            bus.cfg_addr = (i == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            bus.cfg_data = (i == 0) ? 4'd9 : 4'($urandom_range(0, 15));
            step(irdy, ov, o);
        end
        bus.cfg_we = 1'b0;
        lookup_once(48'h0, o, lat);
        checks++; if (o !== 32'hEFA72C4D) begin errors++; $display("FAIL oor_zero got %h want efa72c4d", o); end
        for (int i = 0; i < 12; i++) begin
            w = rand_word();
            lookup_once(w, o, lat);
            checks++; if (o !== ref_word(w)) begin errors++; $display("FAIL oor_lookup in %h got %h want %h", w, o, ref_word(w)); end
        end
    endtask

    task automatic test_random_stream();
        logic [31:0] o;
        logic irdy, ov;
        int b, a, d;
        for (int i = 0; i < 12; i++) begin
            b = (i == 11) ? 9 : $urandom_range(0, 7);
            a = $urandom_range(0, 63);
            d = $urandom_range(0, 15);
            bus.cfg_we = 1'b1; bus.cfg_box = 4'(b); bus.cfg_addr = 6'(a); bus.cfg_data = 4'(d);
            step(irdy, ov, o);
            if (b < 8) ref_tbl[b][a] = d;
        end
        bus.cfg_we = 1'b0;
        run_stream(150, 1'b0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        test_reset();
        test_basic_lookup();
        test_lane4();
        test_backpressure();
        test_table_write();
        test_reset_restore();
        test_same_cycle_write();
        test_out_of_range();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/des_sbox_bank.md
DES_SBOX_BANK -- requirements
Module: des_sbox_bank

Interface
REQ-001 Parameter NUM_BOX, default 8, number of parallel 6-to-4 S-box lanes (1..16).
REQ-002 Parameter LOADABLE, default 1, enables the runtime table-write port; when 0 the cfg_* inputs are ignored.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts the input word this cycle.
REQ-007 in  input  6*NUM_BOX  lane inputs; lane 0 (DES S1) is the most significant 6-bit slice.
REQ-008 out_valid  output  1  output word present.
REQ-009 out_ready  input  1  downstream accepts the output word.
REQ-010 out  output  4*NUM_BOX  lane outputs; lane 0 is the most significant 4-bit slice.
REQ-011 cfg_we  input  1  table write strobe.
REQ-012 cfg_box  input  4  target lane index.
REQ-013 cfg_addr  input  6  table entry index.
REQ-014 cfg_data  input  4  new entry value.

Function
REQ-015 Each lane SHALL hold a 64x4 table indexed directly by its raw 6-bit input value, with DES row/column folding built into the table contents.
REQ-016 Lane k SHALL default to standard DES table S((k mod 8)+1).
REQ-017 The datapath SHALL have two register stages, S1 (captured input) and S2 (output register driving out/out_valid).
REQ-018 A transfer SHALL occur on in_valid && in_ready, and S1 SHALL capture in on that edge.
REQ-019 Lookup SHALL be combinational from the S1 contents, and its result SHALL be loaded into S2 when S1 is valid and S2 is empty or out_ready=1.
REQ-020 Latency SHALL be exactly 2 cycles from acceptance to out_valid when there is no backpressure.
REQ-021 Throughput SHALL be 1 word per cycle.
REQ-022 in_ready SHALL equal !S1_valid || !out_valid || out_ready.
REQ-023 While out_valid=1 && out_ready=0, out SHALL hold stable.
REQ-024 Under sustained backpressure, at most 2 words SHALL be held, and no word SHALL be lost or duplicated.
REQ-025 Words SHALL leave in acceptance order.
REQ-026 A cfg_we write (LOADABLE=1) SHALL update table[cfg_box][cfg_addr] on the clock edge.
REQ-027 A lookup evaluated in the same cycle as a write SHALL use the pre-write contents; the new value SHALL be visible from the next cycle.
REQ-028 A write with cfg_box >= NUM_BOX SHALL be ignored with no side effects.
REQ-029 Table writes SHALL NOT stall or alter the handshake.
REQ-030 Words already captured in S2 SHALL NOT be recomputed after a table write.

Reset
REQ-031 On rst assertion, S1_valid, out_valid and out SHALL go to 0 immediately, independent of clk.
REQ-032 On reset, all tables SHALL return to the standard DES contents.
REQ-033 During reset, in_ready SHALL be 0.
REQ-034 in_ready SHALL be 1 from the first clk edge after rst deasserts.
REQ-035 A reset in mid-stream SHALL discard in-flight words, and no stale word SHALL emerge after reset.

Structure
REQ-036 Package des_pkg SHALL hold the eight standard S-box tables as constants (8x64x4) and a lane-width localparam/function.
REQ-037 Sub-module des_sbox_lut SHALL implement one loadable 64x4 table with its reset default chosen by a box-number parameter; it SHALL be instantiated NUM_BOX times.

Verification
REQ-038 Basic lookup: NUM_BOX=8, in=0, out_ready=1 -> out=32'hEFA72C4D, out_valid exactly 2 cycles after acceptance.
REQ-039 Lane-4 spot check: lane-4 slice=1, others 0 -> out=32'hEFA7EC4D; lane-4 slice=63 -> out=32'hEFA73C4D.
REQ-040 Backpressure: stream 6 distinct words with out_ready low for cycles 3-5 -> in_ready low while 2 words are held; all 6 outputs are correct, in order, and unduplicated.
REQ-041 Table write: write lane 4, addr 0, data 9; then in=0 -> out=32'hEFA79C4D. Same-cycle write+lookup at addr 0 -> old value 2.
REQ-042 Reset restore: after the REQ-041 write, pulse rst mid-stream -> out_valid drops immediately, no stale output appears, and in=0 then yields 32'hEFA72C4D.
REQ-043 Out-of-range write: NUM_BOX=8, cfg_box=12 -> all lookups unchanged.
